// File: rtl/ceespu_interrupt_controller_if.sv
// Bus and interrupt handshake signals between the CPU core and the interrupt controller.
// The core side uses the master modport; the controller uses the slave modport.
interface ceespu_interrupt_controller_if;
    logic [15:0] I_memAddress;
    logic        I_memE;
    logic [3:0]  I_memWe;
    logic [31:0] I_memWData;
    logic [31:0] O_memRData;
    logic        O_sel;
    logic        I_int_ack;
    logic        O_int_req;
    logic [2:0]  O_int_vector;

    modport master (
        output I_memAddress, I_memE, I_memWe, I_memWData, I_int_ack,
        input  O_memRData, O_sel, O_int_req, O_int_vector
    );

    modport slave (
        input  I_memAddress, I_memE, I_memWe, I_memWData, I_int_ack,
        output O_memRData, O_sel, O_int_req, O_int_vector
    );
endinterface

// File: rtl/ceespu_interrupt_controller.sv
// Prioritising interrupt controller: synchronised sources, edge/level capture,
// pending/enable registers, lowest-index-wins request FSM and dmem-mapped registers.
module ceespu_interrupt_controller #(
    parameter int unsigned NUM_SRC   = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic [NUM_SRC-1:0] I_irq,
    ceespu_interrupt_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] sync1_q, sync2_q, dly_q;
    logic [NUM_SRC-1:0] pend_q, pend_d, enable_q, enable_d, edge_q, edge_d;
    logic               req_q, req_d;
    logic [2:0]         vec_q, vec_d, svc_vec_q, svc_vec_d;
    logic               sel_q, sel_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               hit, wr, rd, eoi, any_elig, ack_take;
    logic [2:0]         offs, prio;
    logic [NUM_SRC-1:0] rise, pend_view, elig, w1c, ack_clr;
    logic [7:0]         elig8;
    logic               unused_bits;

    assign unused_bits = ^{bus.I_memAddress[1:0], bus.I_memWData};

    always_comb begin
        hit  = bus.I_memE && (bus.I_memAddress[15:5] == BASE_ADDR[15:5]);
        wr   = hit && (bus.I_memWe != '0);
        rd   = hit && (bus.I_memWe == '0);
        offs = bus.I_memAddress[4:2];
        eoi  = wr && (offs == 3'd4);
        rise = sync2_q & ~dly_q;
        // Level-mode bits are the live synchronised line, never stored.
        pend_view = (pend_q & edge_q) | (sync2_q & ~edge_q);
        elig      = pend_view & enable_q;
        elig8     = 8'(elig);
        prio      = '0;
        any_elig  = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (elig[i] && !any_elig) begin
                prio     = 3'(i);
                any_elig = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        vec_d     = vec_q;
        svc_vec_d = svc_vec_q;
        ack_take  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_elig) begin
                    vec_d   = prio;
                    req_d   = 1'b1;
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                if (bus.I_int_ack) begin
                    ack_take  = 1'b1;
                    svc_vec_d = vec_q;
                    req_d     = 1'b0;
                    state_d   = SERVICE;
                end else if (!elig8[vec_q]) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    svc_vec_d = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        enable_d = enable_q;
        edge_d   = edge_q;
        w1c      = '0;
        if (wr) begin
            case (offs)
                3'd0:    w1c      = bus.I_memWData[NUM_SRC-1:0];
                3'd1:    enable_d = bus.I_memWData[NUM_SRC-1:0];
                3'd2:    edge_d   = bus.I_memWData[NUM_SRC-1:0];
                default: ;
            endcase
        end
        ack_clr = ack_take ? NUM_SRC'(8'b1 << vec_q) : '0;
        // A fresh rising edge outranks any clear in the same cycle.
        pend_d  = ((pend_q & ~w1c & ~ack_clr) | rise) & edge_q;
        rdata_d = '0;
        if (rd) begin
            case (offs)
                3'd0:    rdata_d = 32'(pend_view);
                3'd1:    rdata_d = 32'(enable_q);
                3'd2:    rdata_d = 32'(edge_q);
                3'd3:    rdata_d = {state_q == SERVICE, 22'b0, req_q, 5'b0, svc_vec_q};
                default: rdata_d = '0;
            endcase
        end
        sel_d = hit;
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            state_q   <= IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            dly_q     <= '0;
            pend_q    <= '0;
            enable_q  <= '0;
            edge_q    <= '0;
            req_q     <= 1'b0;
            vec_q     <= '0;
            svc_vec_q <= '0;
            sel_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= I_irq;
            sync2_q   <= sync1_q;
            dly_q     <= sync2_q;
            pend_q    <= pend_d;
            enable_q  <= enable_d;
            edge_q    <= edge_d;
            req_q     <= req_d;
            vec_q     <= vec_d;
            svc_vec_q <= svc_vec_d;
            sel_q     <= sel_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.O_int_req    = req_q;
    assign bus.O_int_vector = vec_q;
    assign bus.O_memRData   = rdata_q;
    assign bus.O_sel        = sel_q;
endmodule
